// File: rtl/csa_resolver.sv
`default_nettype none
// ============================================================================
// Module   : csa_resolver
// Purpose  : Sequential carry-propagate adder that turns a carry-save pair
//            (sum vector, carry vector) into a binary result, resolving
//            CHUNK bits per clock with the carry held in a register.
// Revision : 1.0 - initial release
// ============================================================================
module csa_resolver #(
  parameter int BITS  = 64,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] s_in,
  input  logic [BITS-1:0] c_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            busy
);

  localparam int NCHUNK = BITS / CHUNK;
  // Keep the index at least one bit wide so NCHUNK = 1 still elaborates.
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   s_q, s_d;
  logic [BITS-1:0]   c_q, c_d;
  logic [BITS-1:0]   sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [CHUNK-1:0]  w_s_chunk;
  logic [CHUNK-1:0]  w_c_chunk;
  logic [CHUNK:0]    w_add;

  // One chunk of the ripple: operand slices at the current index plus the held carry.
  always_comb begin
    w_s_chunk = s_q[idx_q*CHUNK +: CHUNK];
    w_c_chunk = c_q[idx_q*CHUNK +: CHUNK];
    w_add     = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  // State register and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update: accept in IDLE, one chunk per ADD cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          s_d     = s_in;
          c_d     = c_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[idx_q*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
        carry_d = w_add[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = w_add[CHUNK];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags come straight from the state register, so no input-to-output path exists.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_resolver
// Purpose  : Self-checking bench for csa_resolver (BITS=64, CHUNK=8) plus a
//            single-chunk instance (CHUNK=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [63:0] s_in, c_in, sum;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cout1, busy1;
  logic [63:0] s_in1, c_in1, sum1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [64:0] sb_q[$];

  always #5 clk = ~clk;

  csa_resolver #(.BITS(64), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .s_in(s_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .busy(busy)
  );

  csa_resolver #(.BITS(64), .CHUNK(64)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .s_in(s_in1), .c_in(c_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1),
    .busy(busy1)
  );

  // Reference 3:2 compressor standing in for the upstream csa block.
  function automatic logic [63:0] csa_s(input logic [63:0] x, y, z);
    return x ^ y ^ z;
  endfunction
  function automatic logic [63:0] csa_c(input logic [63:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  function automatic logic [64:0] pop_exp();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  // Drive one pair until accepted and record the expected result.
  task automatic send_op(input logic [63:0] s, input logic [63:0] c, input logic [64:0] exp);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    s_in = s; c_in = c; in_valid = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, reporting the edge count and whether in_ready stayed low.
  task automatic wait_valid(output int cyc, output bit rdy_low);
    cyc = 0; rdy_low = 1'b1;
    while (!out_valid && cyc < 50) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    if (in_ready) rdy_low = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; s_in = '0; c_in = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; s_in1 = '0; c_in1 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b required 0", busy); end
    n_vec++; if ({cout, sum} !== 65'd0) begin n_err++; $display("FAIL rst_result got %h required 0", {cout, sum}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit rl; logic [64:0] exp;
    send_op(64'h00000000000000FF, 64'h0000000000000001, 65'h0_0000000000000100);
    wait_valid(cyc, rl);
    exp = pop_exp();
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL basic_latency got %0d required 8", cyc); end
    n_vec++; if (rl !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_low got %b required 1", rl); end
    n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL basic_result got %h required %h", {cout, sum}, exp); end
    release_out();
    n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL basic_return got %b required 10", {in_ready, out_valid}); end
  endtask

  task automatic test_carry();
    logic [63:0] sv[2] = '{64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000};
    logic [63:0] cv[2] = '{64'h0000000000000001, 64'h8000000000000000};
    int cyc; bit rl; logic [64:0] exp;
    for (int i = 0; i < 2; i++) begin
      send_op(sv[i], cv[i], {1'b1, 64'h0});
      wait_valid(cyc, rl);
      exp = pop_exp();
      n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL carry_%0d got %h required %h", i, {cout, sum}, exp); end
      release_out();
    end
  endtask

  task automatic test_csa();
    logic [63:0] x, y, z;
    int cyc; bit rl; logic [64:0] exp;
    for (int i = 0; i <= 1000; i++) begin
      if (i == 0) begin
        x = 64'd5; y = 64'd9; z = 64'd3;
      end else begin
        x = {$urandom, $urandom} & 64'h3FFFFFFFFFFFFFFF;
        y = {$urandom, $urandom} & 64'h3FFFFFFFFFFFFFFF;
        z = {$urandom, $urandom} & 64'h3FFFFFFFFFFFFFFF;
      end
      send_op(csa_s(x, y, z), csa_c(x, y, z), 65'(x) + 65'(y) + 65'(z));
      wait_valid(cyc, rl);
      exp = pop_exp();
      n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL csa_%0d got %h required %h", i, {cout, sum}, exp); end
      release_out();
    end
  endtask

  task automatic test_hold();
    int cyc; bit rl; logic [64:0] exp;
    send_op(64'h0123456789ABCDEF, 64'h1111111111111110, 65'h0_0123456789ABCDEF + 65'h0_1111111111111110);
    wait_valid(cyc, rl);
    exp = pop_exp();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      s_in = {$urandom, $urandom}; c_in = {$urandom, $urandom};
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, exp}) begin
        n_err++;
        $display("FAIL hold_%0d got v=%b r=%b res=%h required v=1 r=0 res=%h", i, out_valid, in_ready, {cout, sum}, exp);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL hold_release got %b required 10", {in_ready, out_valid}); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_no_capture busy got %b required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit rl; logic [64:0] exp;
    send_op(64'h1111111111111111, 64'h2222222222222222, 65'h0_3333333333333333);
    repeat (3) begin @(posedge clk); #1; end
    n_vec++; if (sum !== 64'h0000000000333333) begin n_err++; $display("FAIL mid_partial got %h required 0000000000333333", sum); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, busy, in_ready, cout, sum} !== {3'b001, 65'd0}) begin
      n_err++;
      $display("FAIL mid_reset got v=%b b=%b r=%b res=%h required v=0 b=0 r=1 res=0", out_valid, busy, in_ready, {cout, sum});
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_op(64'd3, 64'd4, 65'd7);
    wait_valid(cyc, rl);
    exp = pop_exp();
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL mid_after_latency got %0d required 8", cyc); end
    n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL mid_after_result got %h required %h", {cout, sum}, exp); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc = 0, acc0 = -1, acc1 = -1, got = 0;
    logic [64:0] exp;
    out_ready = 1'b1;
    s_in = 64'd1; c_in = 64'd2; in_valid = 1'b1;
    while (got < 2 && cyc < 60) begin
      if (out_valid && out_ready) begin
        exp = pop_exp();
        n_vec++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL b2b_result_%0d got %h required %h", got, {cout, sum}, exp); end
        got++;
      end
      if (in_valid && in_ready) begin
        if (acc0 < 0) begin acc0 = cyc; sb_q.push_back(65'd3); end
        else begin acc1 = cyc; sb_q.push_back(65'd30); end
      end
      @(posedge clk); #1; cyc++;
      if (acc0 >= 0 && acc1 < 0) begin s_in = 64'd10; c_in = 64'd20; end
      if (acc1 >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (got !== 2) begin n_err++; $display("FAIL b2b_count got %0d required 2", got); end
    n_vec++; if (acc1 - acc0 !== 10) begin n_err++; $display("FAIL b2b_spacing got %0d required 10", acc1 - acc0); end
  endtask

  task automatic test_nchunk1();
    s_in1 = 64'hFFFFFFFFFFFFFFFF; c_in1 = 64'd5; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n_vec++; if ({out_valid1, busy1} !== 2'b01) begin n_err++; $display("FAIL n1_add got v=%b b=%b required v=0 b=1", out_valid1, busy1); end
    @(posedge clk); #1;
    n_vec++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL n1_valid got %b required 1", out_valid1); end
    n_vec++; if ({cout1, sum1} !== {1'b1, 64'd4}) begin n_err++; $display("FAIL n1_result got %h required 10000000000000004", {cout1, sum1}); end
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL n1_return got %b required 1", in_ready1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_csa();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_nchunk1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
